// File: rtl/frame_capture.sv
// Single-frame capture buffer: records one gap-free, start-pulsed pixel stream into RAM,
// then drains it in raster order through a valid/ready port with row and frame markers.
module frame_capture #(
  parameter int WIDTH  = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             sof_in,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_eol,
  output logic             rd_last,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);

  localparam int N     = IMG_W * IMG_H;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [COL_W-1:0]  rd_col_q, rd_col_d;
  logic              rd_issued_q, rd_issued_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_eol_q, rd_eol_d;
  logic              rd_last_q, rd_last_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  rd_data_q;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              rd_load;

  logic [WIDTH-1:0]  mem [N];

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_col_d     = rd_col_q;
    rd_issued_d  = rd_issued_q;
    rd_valid_d   = rd_valid_q;
    rd_eol_d     = rd_eol_q;
    rd_last_d    = rd_last_q;
    frame_done_d = 1'b0;
    err_d        = err_q | (sof_in && (state_q != IDLE));
    we           = 1'b0;
    waddr        = wr_addr_q;
    rd_load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (sof_in) begin
          we        = 1'b1;
          waddr     = '0;
          wr_addr_d = ADDR_W'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        we = 1'b1;
        if (wr_addr_q == LAST_ADDR) begin
          state_d      = DRAIN;
          frame_done_d = 1'b1;
          wr_addr_d    = '0;
          rd_addr_d    = '0;
          rd_col_d     = '0;
          rd_issued_d  = 1'b0;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (rd_valid_q && rd_ready && rd_last_q) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
          rd_eol_d   = 1'b0;
          rd_last_d  = 1'b0;
        end else if (!rd_issued_q && (!rd_valid_q || rd_ready)) begin
          // Output register doubles as the RAM read register, so loading it on
          // every free or consumed slot gives one pixel per cycle.
          rd_load    = 1'b1;
          rd_valid_d = 1'b1;
          rd_eol_d   = (rd_col_q == LAST_COL);
          rd_last_d  = (rd_addr_q == LAST_ADDR);
          rd_col_d   = (rd_col_q == LAST_COL) ? '0 : rd_col_q + COL_W'(1);
          if (rd_addr_q == LAST_ADDR) rd_issued_d = 1'b1;
          else                        rd_addr_d   = rd_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_col_q     <= '0;
      rd_issued_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_eol_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_col_q     <= rd_col_d;
      rd_issued_q  <= rd_issued_d;
      rd_valid_q   <= rd_valid_d;
      rd_eol_q     <= rd_eol_d;
      rd_last_q    <= rd_last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      if (rd_load) rd_data_q <= mem[rd_addr_q];
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= pix_in;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_eol     = rd_eol_q;
  assign rd_last    = rd_last_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture on a 16x16 frame: ramp, backpressure, rejected sof,
// asynchronous reset mid-capture and back-to-back frames.
module tb_frame_capture;

  localparam int WIDTH  = 8;
  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int ADDR_W = 8;
  localparam int N      = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] pix_in = '0;
  logic             sof_in = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b1;
  logic             rd_eol;
  logic             rd_last;
  logic             busy;
  logic             frame_done;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;

  frame_capture #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .sof_in    (sof_in),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_eol    (rd_eol),
    .rd_last   (rd_last),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int mode, input int k);
    case (mode)
      0:       return 8'(k % 256);
      1:       return 8'(255 - (k % 256));
      default: return 8'(k * 7 + 3);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"},    rd_data,    0);
    check({tag, "_rd_valid"},   rd_valid,   0);
    check({tag, "_rd_eol"},     rd_eol,     0);
    check({tag, "_rd_last"},    rd_last,    0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_err"},        err,        0);
  endtask

  task automatic send_frame(input int mode, input int npix, input int bad_k);
    for (int k = 0; k < npix; k++) begin
      sof_in = (k == 0) || (k == bad_k);
      pix_in = exp_pix(mode, k);
      tick();
      if (k == 0)     check("busy_e0", busy, 1);
      if (k == bad_k) check("err_set_capture", err, 1);
      if (k == N - 2) check("fdone_early", frame_done, 0);
      if (k == N - 1) begin
        check("fdone_pulse", frame_done, 1);
        check("busy_capture_end", busy, 1);
      end
    end
    sof_in = 1'b0;
  endtask

  task automatic drain(input int mode, input bit stall, input bit sof_at_last, input bit expect_err);
    int idx;
    int cyc;
    bit done;
    bit rdy;
    idx  = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 4 * N + 20) begin
      rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      rd_ready = rdy;
      if (cyc == 1) check("fdone_clear", frame_done, 0);
      if (rd_valid) begin
        check("rd_data", rd_data, exp_pix(mode, idx));
        check("rd_eol", rd_eol, ((idx % IMG_W) == IMG_W - 1));
        check("rd_last", rd_last, (idx == N - 1));
        if (rdy) begin
          if (idx == N - 1) begin
            done   = 1'b1;
            sof_in = sof_at_last;
          end
          idx++;
        end
      end
      tick();
      cyc++;
    end
    sof_in   = 1'b0;
    rd_ready = 1'b1;
    check("drain_done", done, 1);
    check("drain_count", idx, N);
    if (!stall) check("drain_cycles", cyc, N + 1);
    check("valid_after_last", rd_valid, 0);
    check("busy_after_last", busy, 0);
    check("err_after_drain", err, expect_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Ramp frame, full throughput.
    send_frame(0, N, -1);
    drain(0, 1'b0, 1'b0, 1'b0);

    // Backpressure with ready pattern 1,0,0,1.
    send_frame(2, N, -1);
    drain(2, 1'b1, 1'b0, 1'b0);

    // Rejected sof during capture and on the rd_last transfer edge.
    send_frame(0, N, 100);
    drain(0, 1'b0, 1'b1, 1'b1);
    tick();
    check("busy_after_rejected_sof", busy, 0);
    check("err_sticky", err, 1);

    // Asynchronous reset mid-capture.
    send_frame(1, 50, -1);
    check("busy_mid_capture", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(2, N, -1);
    drain(2, 1'b1, 1'b0, 1'b0);

    // Back-to-back frames: second sof on the edge after the rd_last transfer.
    send_frame(0, N, -1);
    drain(0, 1'b0, 1'b0, 1'b0);
    send_frame(1, N, -1);
    drain(1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
